// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the alarm clock core.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_TIME_H,
        ST_SET_TIME_M,
        ST_SET_ALM_H,
        ST_SET_ALM_M
    } state_t;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;

    localparam logic [1:0] EDIT_NONE = 2'd0;
    localparam logic [1:0] EDIT_HOUR = 2'd1;
    localparam logic [1:0] EDIT_MIN  = 2'd2;

    // Two-digit BCD increment, wrapping to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
        if (value == max)
            return 8'h00;
        if (value[3:0] == 4'd9)
            return {value[7:4] + 4'd1, 4'd0};
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter; load has priority over increment.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_q,
    output logic       o_wrap
);

    logic [7:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_q <= 8'h00;
        else if (i_load)
            r_q <= i_load_val;
        else if (i_en)
            r_q <= bcd_inc(r_q, MAX);
    end

    assign o_q    = r_q;
    assign o_wrap = (r_q == MAX);

endmodule

// File: rtl/alarm_clock_core.sv
// BCD time-of-day with NUM_ALARMS alarm slots, button set FSM, ring timeout and snooze.
module alarm_clock_core
    import clock_pkg::*;
#(
    parameter  int NUM_ALARMS = 2,
    parameter  int RING_SECS  = 60,
    parameter  int SNOOZE_MIN = 5,
    localparam int ALM_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tick_1hz,
    input  logic                  i_mode_btn,
    input  logic                  i_inc_btn,
    input  logic [ALM_W-1:0]      i_alm_sel,
    input  logic [NUM_ALARMS-1:0] i_alarm_en,
    input  logic                  i_stop_btn,
    input  logic                  i_snooze_btn,
    output logic [7:0]            o_hour_bcd,
    output logic [7:0]            o_min_bcd,
    output logic [7:0]            o_sec_bcd,
    output logic [7:0]            o_disp_hour,
    output logic [7:0]            o_disp_min,
    output logic [1:0]            o_edit_field,
    output logic                  o_ringing,
    output logic [ALM_W-1:0]      o_ring_id,
    output logic                  o_snoozed
);

    localparam logic [7:0]  RING_LOAD = 8'(RING_SECS);
    localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_edit_field, w_edit_nxt;
    logic [15:0]      r_alarm [NUM_ALARMS];
    logic             r_ringing, r_snoozed;
    logic [ALM_W-1:0] r_ring_id;
    logic [7:0]       r_ring_cnt;
    logic [11:0]      r_snz_cnt;

    logic [7:0]       w_sec, w_min, w_hour, w_nxt_min, w_nxt_hour;
    logic             w_sec_wrap, w_min_wrap, w_hour_wrap;
    logic             w_time_runs, w_tick, w_inc, w_sel_ok, w_in_alm, w_stop;
    logic             w_match;
    logic [ALM_W-1:0] w_match_id;
    logic [15:0]      w_sel_alarm;

    assign w_time_runs = (r_state == ST_RUN) || w_in_alm;
    assign w_in_alm    = (r_state == ST_SET_ALM_H) || (r_state == ST_SET_ALM_M);
    assign w_tick      = i_tick_1hz && w_time_runs;
    assign w_inc       = i_inc_btn && !i_mode_btn;
    assign w_sel_ok    = 32'(i_alm_sel) < 32'(NUM_ALARMS);

    bcd_mod_counter #(.MAX(BCD_59)) u_sec (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (w_tick),
        .i_load     ((r_state == ST_SET_TIME_M) && i_mode_btn),
        .i_load_val (8'h00),
        .o_q        (w_sec),
        .o_wrap     (w_sec_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_59)) u_min (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       ((w_tick && w_sec_wrap) || (w_inc && r_state == ST_SET_TIME_M)),
        .i_load     (1'b0),
        .i_load_val (8'h00),
        .o_q        (w_min),
        .o_wrap     (w_min_wrap)
    );

    bcd_mod_counter #(.MAX(BCD_23)) u_hour (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       ((w_tick && w_sec_wrap && w_min_wrap) || (w_inc && r_state == ST_SET_TIME_H)),
        .i_load     (1'b0),
        .i_load_val (8'h00),
        .o_q        (w_hour),
        .o_wrap     (w_hour_wrap)
    );

    // Matching only matters when seconds roll to 00, so next hh:mm is the carried value.
    assign w_nxt_min  = bcd_inc(w_min, BCD_59);
    assign w_nxt_hour = !w_min_wrap ? w_hour : (w_hour_wrap ? 8'h00 : bcd_inc(w_hour, BCD_23));

    always_comb begin
        w_match    = 1'b0;
        w_match_id = '0;
        if (w_tick && w_sec_wrap) begin
            for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
                if (i_alarm_en[i] && r_alarm[i] == {w_nxt_hour, w_nxt_min}) begin
                    w_match    = 1'b1;
                    w_match_id = ALM_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_alarm = 16'h0000;
        for (int i = 0; i < NUM_ALARMS; i++)
            if (32'(i_alm_sel) == 32'(i))
                w_sel_alarm = r_alarm[i];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_edit_nxt  = EDIT_NONE;
        if (i_mode_btn) begin
            case (r_state)
                ST_RUN:        w_state_nxt = ST_SET_TIME_H;
                ST_SET_TIME_H: w_state_nxt = ST_SET_TIME_M;
                ST_SET_TIME_M: w_state_nxt = ST_SET_ALM_H;
                ST_SET_ALM_H:  w_state_nxt = ST_SET_ALM_M;
                default:       w_state_nxt = ST_RUN;
            endcase
        end
        case (w_state_nxt)
            ST_SET_TIME_H, ST_SET_ALM_H: w_edit_nxt = EDIT_HOUR;
            ST_SET_TIME_M, ST_SET_ALM_M: w_edit_nxt = EDIT_MIN;
            default:                     w_edit_nxt = EDIT_NONE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_edit_field <= EDIT_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_edit_field <= w_edit_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++)
                r_alarm[i] <= 16'h0000;
        end else if (w_inc && w_sel_ok && w_in_alm) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (32'(i_alm_sel) == 32'(i)) begin
                    if (r_state == ST_SET_ALM_H)
                        r_alarm[i][15:8] <= bcd_inc(r_alarm[i][15:8], BCD_23);
                    else
                        r_alarm[i][7:0] <= bcd_inc(r_alarm[i][7:0], BCD_59);
                end
            end
        end
    end

    // Disarming the active slot behaves exactly like the stop button.
    assign w_stop = i_stop_btn || ((r_ringing || r_snoozed) && !i_alarm_en[r_ring_id]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ringing  <= 1'b0;
            r_snoozed  <= 1'b0;
            r_ring_id  <= '0;
            r_ring_cnt <= 8'd0;
            r_snz_cnt  <= 12'd0;
        end else if (w_stop) begin
            r_ringing  <= 1'b0;
            r_snoozed  <= 1'b0;
            r_ring_cnt <= 8'd0;
            r_snz_cnt  <= 12'd0;
        end else if (r_ringing) begin
            if (i_snooze_btn) begin
                r_ringing  <= 1'b0;
                r_snoozed  <= 1'b1;
                r_ring_cnt <= 8'd0;
                r_snz_cnt  <= SNZ_LOAD;
            end else if (i_tick_1hz) begin
                r_ring_cnt <= r_ring_cnt - 8'd1;
                if (r_ring_cnt == 8'd1)
                    r_ringing <= 1'b0;
            end
        end else if (w_match) begin
            r_ringing  <= 1'b1;
            r_snoozed  <= 1'b0;
            r_ring_id  <= w_match_id;
            r_ring_cnt <= RING_LOAD;
            r_snz_cnt  <= 12'd0;
        end else if (r_snoozed && i_tick_1hz) begin
            r_snz_cnt <= r_snz_cnt - 12'd1;
            if (r_snz_cnt == 12'd1) begin
                r_snoozed  <= 1'b0;
                r_ringing  <= 1'b1;
                r_ring_cnt <= RING_LOAD;
            end
        end
    end

    assign o_hour_bcd   = w_hour;
    assign o_min_bcd    = w_min;
    assign o_sec_bcd    = w_sec;
    assign o_disp_hour  = (w_in_alm && w_sel_ok) ? w_sel_alarm[15:8] : w_hour;
    assign o_disp_min   = (w_in_alm && w_sel_ok) ? w_sel_alarm[7:0]  : w_min;
    assign o_edit_field = r_edit_field;
    assign o_ringing    = r_ringing;
    assign o_ring_id    = r_ring_id;
    assign o_snoozed    = r_snoozed;

endmodule
